game_ctrl: RTL and testbench

- Front-end sequencer for the maze game datapath (room/sword pair).
- Synchronises raw direction buttons and turns each press into a single-cycle one-hot move pulse.
- Arbitrates simultaneous presses and rate-limits moves.
- Sequences game phases (idle, clear, play, over): drives the datapath's game reset and freezes moves once win or death is reported.

---
 rtl/game_ctrl_if.sv | 17 +
 rtl/game_ctrl.sv | 179 +++++++++++++++++
 tb/tb_game_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Datapath-facing bundle between the game controller and the room/sword
// datapath.
//   n/s/e/w  : one-hot move pulses, controller -> datapath
//   game_rst : active-high datapath reset, controller -> datapath
//   win/d    : win and death status, datapath -> controller
interface game_ctrl_if;
    logic n;
    logic s;
    logic e;
    logic w;
    logic game_rst;
    logic win;
    logic d;

    modport master (output n, s, e, w, game_rst, input win, d);
    modport slave  (input n, s, e, w, game_rst, output win, d);
endinterface

// File: rtl/game_ctrl.sv
// Front-end sequencer for the maze game datapath.
// Synchronises raw buttons, turns each press into one single-cycle one-hot
// move pulse (priority N > E > S > W, cooldown between moves), and runs the
// IDLE -> CLEAR -> PLAY -> OVER phase machine that drives the datapath reset.
// Ports:
//   clk                      : system clock, rising edge
//   reset                    : asynchronous active-low reset
//   n_btn/s_btn/e_btn/w_btn  : raw direction buttons (asynchronous)
//   start                    : raw start button (asynchronous)
//   dp                       : datapath bundle (move pulses, game_rst, win, d)
//   moves                    : saturating count of issued moves
//   phase                    : 0=IDLE 1=CLEAR 2=PLAY 3=OVER
module game_ctrl #(
    parameter int COOLDOWN   = 4,
    parameter int CLR_CYCLES = 2,
    parameter int OVER_HOLD  = 16,
    parameter int MW         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               n_btn,
    input  logic               s_btn,
    input  logic               e_btn,
    input  logic               w_btn,
    input  logic               start,
    game_ctrl_if.master        dp,
    output logic [MW-1:0]      moves,
    output logic [1:0]         phase
);

    localparam int CDW = $clog2(COOLDOWN + 1);
    localparam int CLW = $clog2(CLR_CYCLES + 1);
    localparam int OVW = $clog2(OVER_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Bit order of the synchroniser vectors: {start, w, s, e, n}
    logic [4:0]     sync1_r;
    logic [4:0]     sync2_r;
    logic [4:0]     prev_r;
    logic [4:0]     rise_s;
    logic [3:0]     pick_s;        // {w, s, e, n} after arbitration
    logic           start_rise_s;
    logic           cd_zero_s;

    state_t         state_r;
    logic [3:0]     pulse_r;       // {w, s, e, n}
    logic           game_rst_r;
    logic [MW-1:0]  moves_r;
    logic [CDW-1:0] cd_r;
    logic [CLW-1:0] clr_cnt_r;
    logic [OVW-1:0] over_cnt_r;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 5'b00000;
            sync2_r <= 5'b00000;
            prev_r  <= 5'b00000;
        end else begin
            sync1_r <= {start, w_btn, s_btn, e_btn, n_btn};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise_s       = sync2_r & ~prev_r;
    assign start_rise_s = rise_s[4];
    assign cd_zero_s    = (cd_r == CDW'(0));

    // Fixed-priority pick among simultaneous direction rises; losers vanish
    always_comb begin
        pick_s = 4'b0000;
        if (rise_s[0]) begin
            pick_s = 4'b0001;
        end else if (rise_s[1]) begin
            pick_s = 4'b0010;
        end else if (rise_s[2]) begin
            pick_s = 4'b0100;
        end else if (rise_s[3]) begin
            pick_s = 4'b1000;
        end else begin
            pick_s = 4'b0000;
        end
    end

    // Phase machine with registered outputs computed from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            game_rst_r <= 1'b1;
            pulse_r    <= 4'b0000;
            moves_r    <= {MW{1'b0}};
            cd_r       <= {CDW{1'b0}};
            clr_cnt_r  <= {CLW{1'b0}};
            over_cnt_r <= {OVW{1'b0}};
        end else begin
            pulse_r <= 4'b0000;
            if (!cd_zero_s) begin
                cd_r <= cd_r - CDW'(1);
            end
            case (state_r)
                IDLE: begin
                    game_rst_r <= 1'b1;
                    if (start_rise_s) begin
                        state_r   <= CLEAR;
                        clr_cnt_r <= {CLW{1'b0}};
                        moves_r   <= {MW{1'b0}};
                    end
                end
                CLEAR: begin
                    moves_r <= {MW{1'b0}};
                    if (clr_cnt_r == CLW'(CLR_CYCLES - 1)) begin
                        state_r    <= PLAY;
                        game_rst_r <= 1'b0;
                    end else begin
                        clr_cnt_r  <= clr_cnt_r + CLW'(1);
                        game_rst_r <= 1'b1;
                    end
                end
                PLAY: begin
                    if (start_rise_s) begin
                        // Restart wins over any move on the same edge
                        state_r    <= CLEAR;
                        clr_cnt_r  <= {CLW{1'b0}};
                        moves_r    <= {MW{1'b0}};
                        game_rst_r <= 1'b1;
                    end else if (dp.win || dp.d) begin
                        // Game is decided: freeze moves, even a pending rise
                        state_r    <= OVER;
                        over_cnt_r <= {OVW{1'b0}};
                        game_rst_r <= 1'b0;
                    end else begin
                        game_rst_r <= 1'b0;
                        if (cd_zero_s && (pick_s != 4'b0000)) begin
                            pulse_r <= pick_s;
                            cd_r    <= CDW'(COOLDOWN);
                            if (moves_r != {MW{1'b1}}) begin
                                moves_r <= moves_r + MW'(1);
                            end
                        end
                    end
                end
                OVER: begin
                    if (start_rise_s) begin
                        state_r    <= CLEAR;
                        clr_cnt_r  <= {CLW{1'b0}};
                        moves_r    <= {MW{1'b0}};
                        game_rst_r <= 1'b1;
                    end else if (over_cnt_r == OVW'(OVER_HOLD - 1)) begin
                        state_r    <= IDLE;
                        game_rst_r <= 1'b1;
                    end else begin
                        over_cnt_r <= over_cnt_r + OVW'(1);
                        game_rst_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    game_rst_r <= 1'b1;
                end
            endcase
        end
    end

    assign dp.n        = pulse_r[0];
    assign dp.e        = pulse_r[1];
    assign dp.s        = pulse_r[2];
    assign dp.w        = pulse_r[3];
    assign dp.game_rst = game_rst_r;
    assign moves       = moves_r;
    assign phase       = state_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: a per-cycle vector table for the main game
// flow, then hand-written sequences for saturation, restart and async reset.
module tb_game_ctrl;

    logic       clk;
    logic       reset;
    logic       n_btn, s_btn, e_btn, w_btn, start;
    logic [7:0] moves;
    logic [1:0] phase;
    logic [1:0] sat_moves;
    logic [1:0] sat_phase;

    int total;
    int bad;

    game_ctrl_if dp_if ();
    game_ctrl_if sat_if ();

    game_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .n_btn (n_btn),
        .s_btn (s_btn),
        .e_btn (e_btn),
        .w_btn (w_btn),
        .start (start),
        .dp    (dp_if),
        .moves (moves),
        .phase (phase)
    );

    game_ctrl #(.MW(2)) u_sat (
        .clk   (clk),
        .reset (reset),
        .n_btn (n_btn),
        .s_btn (s_btn),
        .e_btn (e_btn),
        .w_btn (w_btn),
        .start (start),
        .dp    (sat_if),
        .moves (sat_moves),
        .phase (sat_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;   // {n, s, e, w}
        logic       st;
        logic       win;
        logic       dd;
        logic [3:0] pul;   // expected {n, s, e, w}
        logic       grst;
        logic [1:0] ph;
        logic [7:0] mv;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] btn, input logic st, input logic win,
                       input logic dd, input logic [3:0] pul, input logic grst,
                       input logic [1:0] ph, input logic [7:0] mv);
        vec_t v;
        v.btn = btn; v.st = st; v.win = win; v.dd = dd;
        v.pul = pul; v.grst = grst; v.ph = ph; v.mv = mv;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] btn, input logic st, input logic win, input logic dd);
        n_btn = btn[3]; s_btn = btn[2]; e_btn = btn[1]; w_btn = btn[0];
        start = st;
        dp_if.win = win; dp_if.d = dd;
        sat_if.win = win; sat_if.d = dd;
    endtask

    function automatic logic [3:0] pulses();
        return {dp_if.n, dp_if.s, dp_if.e, dp_if.w};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int  seen;
        int  sat_exp;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 1'b0);

        // Game flow table: inputs sampled at edge i, outputs checked after it
        add(4'b0000,0,0,0, 4'b0000,1,2'd0,8'd0);   // v0
        add(4'b0000,0,0,0, 4'b0000,1,2'd0,8'd0);   // v1
        add(4'b0000,1,0,0, 4'b0000,1,2'd0,8'd0);   // v2 start sampled
        add(4'b0000,0,0,0, 4'b0000,1,2'd0,8'd0);   // v3
        add(4'b0000,0,0,0, 4'b0000,1,2'd1,8'd0);   // v4 CLEAR
        add(4'b0000,0,0,0, 4'b0000,1,2'd1,8'd0);   // v5
        add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd0);   // v6 PLAY
        add(4'b1000,0,0,0, 4'b0000,0,2'd2,8'd0);   // v7 n held from here
        add(4'b1000,0,0,0, 4'b0000,0,2'd2,8'd0);   // v8
        add(4'b1000,0,0,0, 4'b1000,0,2'd2,8'd1);   // v9 n pulse
        for (int i = 0; i < 7; i++) add(4'b1000,0,0,0, 4'b0000,0,2'd2,8'd1); // v10-16
        for (int i = 0; i < 3; i++) add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd1); // v17-19
        add(4'b1001,0,0,0, 4'b0000,0,2'd2,8'd1);   // v20 n+w together
        add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd1);   // v21
        add(4'b0010,0,0,0, 4'b1000,0,2'd2,8'd2);   // v22 only n wins; e pressed
        for (int i = 0; i < 3; i++) add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd2); // v23-25 e dropped
        add(4'b0010,0,0,0, 4'b0000,0,2'd2,8'd2);   // v26 e again
        add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd2);   // v27
        add(4'b0000,0,0,0, 4'b0010,0,2'd2,8'd3);   // v28 e pulse
        add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd3);   // v29
        add(4'b0100,0,0,0, 4'b0000,0,2'd2,8'd3);   // v30 s: rises at last cooldown cycle
        add(4'b0001,0,0,0, 4'b0000,0,2'd2,8'd3);   // v31 w: rises first free cycle
        add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd3);   // v32 s dropped
        add(4'b0000,0,0,0, 4'b0001,0,2'd2,8'd4);   // v33 w pulse
        for (int i = 0; i < 4; i++) add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd4); // v34-37
        add(4'b0100,0,0,0, 4'b0000,0,2'd2,8'd4);   // v38 s press
        add(4'b0000,0,0,0, 4'b0000,0,2'd2,8'd4);   // v39
        add(4'b0000,0,1,0, 4'b0000,0,2'd3,8'd4);   // v40 win with s rise: OVER
        for (int i = 0; i < 15; i++) add(4'b0000,0,0,0, 4'b0000,0,2'd3,8'd4); // v41-55
        add(4'b0000,0,0,0, 4'b0000,1,2'd0,8'd4);   // v56 back to IDLE
        add(4'b0000,0,0,0, 4'b0000,1,2'd0,8'd4);   // v57

        // Reset state
        cyc();
        cyc();
        chk("rst phase", phase, 0);
        chk("rst game_rst", dp_if.game_rst, 1);
        chk("rst moves", moves, 0);
        chk("rst pulses", pulses(), 0);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].btn, vq[i].st, vq[i].win, vq[i].dd);
            cyc();
            chk($sformatf("v%0d pulse", i), pulses(), vq[i].pul);
            chk($sformatf("v%0d game_rst", i), dp_if.game_rst, vq[i].grst);
            chk($sformatf("v%0d phase", i), phase, vq[i].ph);
            chk($sformatf("v%0d moves", i), moves, vq[i].mv);
            sat_exp = (vq[i].mv > 8'd3) ? 3 : int'(vq[i].mv);
            chk($sformatf("v%0d sat moves", i), sat_moves, sat_exp);
        end

        // New game, then five spaced presses: MW=2 copy saturates at 3
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (5) cyc();
        chk("newgame phase", phase, 2);
        chk("newgame moves", moves, 0);
        chk("newgame sat moves", sat_moves, 0);
        for (int k = 0; k < 5; k++) begin
            drive(4'b1000, 1'b0, 1'b0, 1'b0);
            cyc();
            drive(4'b0000, 1'b0, 1'b0, 1'b0);
            seen = 0;
            for (int t = 0; t < 6 && seen == 0; t++) begin
                cyc();
                if (dp_if.n) seen = 1;
            end
            chk($sformatf("sat%0d pulse", k), seen, 1);
            chk($sformatf("sat%0d moves", k), moves, k + 1);
            chk($sformatf("sat%0d sat moves", k), sat_moves, (k + 1 > 3) ? 3 : k + 1);
            repeat (6) cyc();
        end

        // Start and n rising together in PLAY: restart, move dropped
        drive(4'b1000, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("restart phase", phase, 1);
        chk("restart pulse", pulses(), 0);
        chk("restart game_rst", dp_if.game_rst, 1);
        chk("restart moves", moves, 0);
        cyc();
        cyc();
        chk("restart play", phase, 2);

        // Death ends the game; async reset mid-OVER acts before the next edge
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        cyc();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("death phase", phase, 3);
        chk("death game_rst", dp_if.game_rst, 0);
        cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("async phase", phase, 0);
        chk("async game_rst", dp_if.game_rst, 1);
        chk("async moves", moves, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        chk("post rst phase", phase, 0);
        chk("post rst moves", moves, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
